// File: rtl/i2c_request_arbiter.sv
// Round-robin share of one I2C controller among NREQ requesters; Go one cycle after grant, Ack/Err one cycle after Done or timeout.
// No backpressure: a requester holds Req until its Ack/Err; arbitration waits while the controller reports busy.
module i2c_request_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [NREQ-1:0]     i_req,
  input  logic [NREQ-1:0]     i_req_rw,
  input  logic [7*NREQ-1:0]   i_req_addr,
  input  logic [DW*NREQ-1:0]  i_req_data,
  output logic [NREQ-1:0]     o_ack,
  output logic [NREQ-1:0]     o_err,
  output logic [DW-1:0]       o_rd_data,
  output logic [1:0]          o_grant_id,
  output logic                o_go,
  output logic                o_i2c_rw,
  output logic [6:0]          o_i2c_addr,
  output logic [DW-1:0]       o_i2c_wr_data,
  input  logic                i_i2c_busy,
  input  logic                i_i2c_done,
  input  logic                i_i2c_nack,
  input  logic [DW-1:0]       i_i2c_rd_data
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [1:0] LAST_RST = 2'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESP} state_t;

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic [1:0]       r_last;
  logic [1:0]       r_grant_id;
  logic             r_go;
  logic [NREQ-1:0]  r_ack;
  logic [NREQ-1:0]  r_err;
  logic [DW-1:0]    r_rd_data;
  logic             r_i2c_rw;
  logic [6:0]       r_i2c_addr;
  logic [DW-1:0]    r_i2c_wr_data;

  int               w_best;
  int               w_dist;
  logic [1:0]       w_win;
  logic             w_rw;
  logic [6:0]       w_addr;
  logic [DW-1:0]    w_data;
  logic [NREQ-1:0]  w_gid_oh;

  // Winner is the requester at the smallest rotational distance past r_last.
  always_comb begin
    w_best = NREQ;
    w_dist = 0;
    w_win  = '0;
    w_rw   = 1'b0;
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + 2 * NREQ - 1 - int'(r_last)) % NREQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = 2'(i);
        w_rw   = i_req_rw[i];
        w_addr = i_req_addr[7*i +: 7];
        w_data = i_req_data[DW*i +: DW];
      end
    end
  end

  assign w_gid_oh = NREQ'(1) << r_grant_id;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_last        <= LAST_RST;
      r_grant_id    <= '0;
      r_go          <= 1'b0;
      r_ack         <= '0;
      r_err         <= '0;
      r_rd_data     <= '0;
      r_i2c_rw      <= 1'b0;
      r_i2c_addr    <= '0;
      r_i2c_wr_data <= '0;
    end else begin
      r_go  <= 1'b0;
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        IDLE: begin
          if ((|i_req) && !i_i2c_busy) begin
            r_grant_id    <= w_win;
            r_i2c_rw      <= w_rw;
            r_i2c_addr    <= w_addr;
            r_i2c_wr_data <= w_data;
            r_go          <= 1'b1;
            r_state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_timer <= '0;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          r_timer <= r_timer + 1'b1;
          // Done takes priority over a timeout landing in the same cycle.
          if (i_i2c_done) begin
            if (!i_i2c_nack && r_i2c_rw) r_rd_data <= i_i2c_rd_data;
            if (i_i2c_nack) r_err <= w_gid_oh;
            else            r_ack <= w_gid_oh;
            r_state <= RESP;
          end else if (r_timer == TLAST) begin
            r_err   <= w_gid_oh;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_last  <= r_grant_id;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ack         = r_ack;
  assign o_err         = r_err;
  assign o_rd_data     = r_rd_data;
  assign o_grant_id    = r_grant_id;
  assign o_go          = r_go;
  assign o_i2c_rw      = r_i2c_rw;
  assign o_i2c_addr    = r_i2c_addr;
  assign o_i2c_wr_data = r_i2c_wr_data;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Randomized bench for i2c_request_arbiter: transaction-level reference model feeds expectation queues; a monitor pops and compares.
module tb_i2c_request_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [7*NREQ-1:0] req_addr = '0;
  logic [DW*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;
  logic [DW-1:0]     rd_data;
  logic [1:0]        grant_id;
  logic              go;
  logic              i2c_rw;
  logic [6:0]        i2c_addr;
  logic [DW-1:0]     i2c_wr_data;
  logic              busy = 1'b0;
  logic              done = 1'b0;
  logic              nack = 1'b0;
  logic [DW-1:0]     i2c_rd = '0;

  always #5 clk = ~clk;

  i2c_request_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req(req), .i_req_rw(req_rw), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_ack(ack), .o_err(err), .o_rd_data(rd_data), .o_grant_id(grant_id),
    .o_go(go), .o_i2c_rw(i2c_rw), .o_i2c_addr(i2c_addr), .o_i2c_wr_data(i2c_wr_data),
    .i_i2c_busy(busy), .i_i2c_done(done), .i_i2c_nack(nack), .i_i2c_rd_data(i2c_rd)
  );

  typedef struct {
    logic [1:0]    id;
    logic          rw;
    logic [6:0]    addr;
    logic [DW-1:0] data;
  } go_t;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] err;
  } resp_t;

  go_t   q_go[$];
  resp_t q_resp[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: phase 0 free, 1 transfer outstanding, 2 response just issued.
  int            m_phase = 0;
  int            m_e = 0;
  int            ed = 0;
  logic [1:0]    m_last = 2'(NREQ - 1);
  logic [1:0]    m_gid = '0;
  logic          m_rw = 1'b0;
  logic [6:0]    m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    int w;
    resp_t r;
    forever begin
      @(posedge clk);
      ed++;
      if (!rst_n) begin
        m_phase = 0;
        m_last  = 2'(NREQ - 1);
        m_gid   = '0;
        m_rw    = 1'b0;
        m_addr  = '0;
        m_wd    = '0;
        m_rd    = '0;
        q_go.delete();
        q_resp.delete();
      end else begin
        case (m_phase)
          0: if (req != '0 && !busy) begin
            w = -1;
            for (int off = 1; off <= NREQ; off++)
              if (w < 0 && req[(int'(m_last) + off) % NREQ]) w = (int'(m_last) + off) % NREQ;
            m_gid  = 2'(w);
            m_rw   = req_rw[w];
            m_addr = req_addr[7*w +: 7];
            m_wd   = req_data[DW*w +: DW];
            q_go.push_back('{m_gid, m_rw, m_addr, m_wd});
            m_e     = ed;
            m_phase = 1;
          end
          1: begin
            // Done counts from the second edge after grant; the window closes TIMEOUT edges later.
            if (ed - m_e >= 2 && done) begin
              r.ack = nack ? '0 : (NREQ'(1) << m_gid);
              r.err = nack ? (NREQ'(1) << m_gid) : '0;
              if (!nack && m_rw) m_rd = i2c_rd;
              q_resp.push_back(r);
              m_phase = 2;
            end else if (ed - m_e == TO + 1) begin
              r.ack = '0;
              r.err = NREQ'(1) << m_gid;
              q_resp.push_back(r);
              m_phase = 2;
            end
          end
          default: begin
            m_last  = m_gid;
            m_phase = 0;
          end
        endcase
      end
    end
  end

  initial begin
    go_t   g;
    resp_t r;
    logic  exp_go;
    forever begin
      @(negedge clk);
      exp_go = (q_go.size() > 0);
      chk("go", 32'(go), 32'(exp_go));
      if (exp_go) begin
        g = q_go.pop_front();
        chk("go_grant_id", 32'(grant_id), 32'(g.id));
        chk("go_rw", 32'(i2c_rw), 32'(g.rw));
        chk("go_addr", 32'(i2c_addr), 32'(g.addr));
        chk("go_wr_data", 32'(i2c_wr_data), 32'(g.data));
      end
      if (q_resp.size() > 0) r = q_resp.pop_front();
      else begin
        r.ack = '0;
        r.err = '0;
      end
      chk("ack", 32'(ack), 32'(r.ack));
      chk("err", 32'(err), 32'(r.err));
      chk("rd_data", 32'(rd_data), 32'(m_rd));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("i2c_addr", 32'(i2c_addr), 32'(m_addr));
      chk("i2c_wr_data", 32'(i2c_wr_data), 32'(m_wd));
    end
  end

  int cnt = -1;

  task automatic run(input logic [NREQ-1:0] mask, input int p_raise, input int p_drop,
                     input int p_busy, input int p_to, input int p_nack, input int dmin,
                     input int dmax, input int p_spur, input int p_rst, input int ncyc);
    req = req & mask;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      if (p_rst > 0 && m_phase == 1 && $urandom_range(999) < p_rst) rst_n = 1'b0;
      busy = ($urandom_range(99) < p_busy);
      done = 1'b0;
      if (go) cnt = ($urandom_range(99) < p_to) ? -1 : int'($urandom_range(dmax, dmin));
      if (cnt == 0) begin
        done   = 1'b1;
        nack   = ($urandom_range(99) < p_nack);
        i2c_rd = DW'($urandom);
      end else if ($urandom_range(99) < p_spur) begin
        done   = 1'b1;
        nack   = 1'($urandom);
        i2c_rd = DW'($urandom);
      end
      if (cnt >= 0) cnt--;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (ack[i] || err[i])) begin
          if ($urandom_range(99) < p_drop) req[i] = 1'b0;
        end else if (!req[i] && mask[i] && $urandom_range(99) < p_raise) begin
          req[i]              = 1'b1;
          req_rw[i]           = 1'($urandom);
          req_addr[7*i +: 7]  = 7'($urandom);
          req_data[DW*i +: DW] = DW'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(4'b0001, 100, 100, 0, 0, 0, 1, 15, 0, 0, 120);
    run(4'b0101, 100, 0, 0, 0, 0, 1, 15, 0, 0, 200);
    run(4'b1111, 100, 0, 0, 0, 20, 1, 15, 0, 0, 300);
    run(4'b0000, 0, 100, 0, 0, 0, 1, 15, 0, 0, 40);
    run(4'b0001, 100, 100, 100, 0, 0, 1, 15, 0, 0, 20);
    run(4'b0001, 100, 100, 0, 0, 0, 1, 15, 0, 0, 40);
    run(4'b0010, 100, 100, 0, 100, 0, 1, 15, 0, 0, 80);
    run(4'b1111, 30, 70, 10, 10, 25, 0, 20, 3, 4, 3000);
    run(4'b0000, 0, 100, 0, 0, 0, 1, 15, 0, 0, 60);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_request_arbiter.md
Name: i2c_request_arbiter

Overview:
Shares the single I2C controller between up to four on-chip requesters, for example a sensor poller, a config loader and a debug port. The block grants one pending request at a time using round-robin arbitration. It latches that request's address, direction and data, and issues a one-cycle Go to the controller. It then waits for the controller's Done, applies a watchdog timeout, and returns a per-requester Ack or Err pulse together with the read data.

Parameters:
NREQ, 4, number of requesters (legal range 2..4)
DW, 8, data byte width
TIMEOUT, 4095, clock cycles allowed in WAIT_DONE before the transaction is aborted with an error

Ports:
clock  in  1  system clock, all logic on the rising edge
Reset  in  1  synchronous, active-low reset (0 = reset)
Req  in  NREQ  request level per requester; must be held until that requester's Ack or Err
ReqRW  in  NREQ  per-requester direction: 1 = read, 0 = write
ReqAddr  in  7*NREQ  per-requester 7-bit slave address; requester i uses bits [7i+6:7i]
ReqData  in  DW*NREQ  per-requester write byte
Ack  out  NREQ  one-cycle success pulse to the granted requester
Err  out  NREQ  one-cycle failure pulse (NACK or timeout)
RdData  out  DW  read byte; valid in the Ack cycle, held until the next Ack
GrantId  out  2  index of the current or last granted requester
Go  out  1  one-cycle start pulse to the I2C controller
I2CRW  out  1  latched direction to the controller
I2CAddr  out  7  latched address to the controller
I2CWrData  out  DW  latched write byte to the controller
I2CBusy  in  1  controller is busy
I2CDone  in  1  controller completion pulse
I2CNack  in  1  slave NACK flag; qualified by I2CDone
I2CRdData  in  DW  controller read byte; qualified by I2CDone

Behaviour:
- All outputs are registered.
- Reset (Reset=0 at a clock edge) forces:
  - state = IDLE;
  - Go, Ack, Err, RdData, I2CRW, I2CAddr, I2CWrData = 0;
  - GrantId = 0 and Last = NREQ-1, so requester 0 has first priority.
- Reset overrides every state, including mid-transaction. No Ack or Err is issued for the aborted transfer. The controller's late I2CDone is ignored because state is IDLE.
- States: IDLE, LAUNCH, WAIT_DONE, RESP.
- IDLE:
  - Condition to leave: at least one Req bit is 1 and I2CBusy=0.
  - Winner: the first requesting index searched in order Last+1, Last+2, … modulo NREQ.
  - On the same edge: latch the winner's ReqRW, ReqAddr and ReqData into I2CRW, I2CAddr and I2CWrData; set GrantId to the winner; move to LAUNCH.
  - While I2CBusy=1, stay in IDLE with no Go.
- LAUNCH:
  - Go=1 for exactly this one cycle.
  - Clear the timer to 0 and move to WAIT_DONE.
  - I2CDone is ignored in this cycle.
- WAIT_DONE:
  - The timer increments by 1 each cycle.
  - On I2CDone=1: capture I2CRdData into RdData only if I2CNack=0 and I2CRW=1. Record error = I2CNack. Move to RESP.
  - When the timer reaches TIMEOUT with no I2CDone: record error = 1, leave RdData unchanged, move to RESP.
  - If I2CDone and timeout occur in the same cycle, I2CDone wins.
- RESP:
  - Exactly one of Ack[GrantId] or Err[GrantId] is 1, for one cycle.
  - Set Last = GrantId and return to IDLE.
- Latency:
  - Req rising at edge n (idle, not busy) → Go high in cycle n+1.
  - I2CDone sampled at edge m → Ack or Err high in cycle m+1.
  - Earliest re-arbitration is the edge after RESP.
- Request withdrawal: if a requester drops Req after grant, the transaction still completes and the pulse is still issued. The requester ignores it.
- Held requests: a Req still high after its Ack is treated as a new request. Round-robin then serves every other pending requester before it again, so there is no starvation.
- Timer width: ceil(log2(TIMEOUT+1)) bits; the timer never wraps.
- Out-of-range Req bits (index ≥ NREQ) do not exist, and GrantId never exceeds NREQ-1.

Test Plan:
1. Req=0001, ReqRW[0]=1, ReqAddr[0]=7'h4B; controller returns Done 40 cycles after Go with RdData=8'hA5, Nack=0 → Go is a single pulse with I2CAddr=4B and I2CRW=1; Ack=0001 one cycle later; RdData=A5; Err stays 0.
2. Req=0101 held continuously, each transfer completing normally → grant order 0,2,0,2; GrantId alternates; each requester receives its Ack.
3. Req=1111 held for 8 transfers → grant order 0,1,2,3,0,1,2,3.
4. TIMEOUT=16; Req=0010 with no Done → Err=0010 exactly 17 cycles after the Go cycle; RdData unchanged; a following request proceeds normally.
5. Done with Nack=1 on a write from requester 3 → Err=1000, Ack=0, I2CWrData equals ReqData[3].
6. Reset=0 for one cycle during WAIT_DONE, then a late I2CDone → no Ack or Err; all outputs 0; a new Req=0001 is granted first.
7. I2CBusy=1 for 20 cycles while Req=0001 → no Go until the cycle after Busy falls.
